// File: rtl/cdc_handshake_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdc_handshake_tx_pkg
// Description : Shared constants for the 4-phase CDC handshake transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package cdc_handshake_tx_pkg;

    localparam logic [1:0] c_ST_IDLE     = 2'b00;
    localparam logic [1:0] c_ST_REQ      = 2'b01;
    localparam logic [1:0] c_ST_WAIT_LOW = 2'b10;

    localparam int c_DEF_NUM_STAGES = 2;

endpackage : cdc_handshake_tx_pkg
`default_nettype wire

// File: rtl/cdc_handshake_tx_ack_sync.sv
`default_nettype none
// ============================================================================
// Module      : ack_sync_stage
// Description : Multi-flop synchronizer bringing the destination ack level
//               into the source clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
module ack_sync_stage
    import cdc_handshake_tx_pkg::*;
#(
    parameter int NUM_STAGES = c_DEF_NUM_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_ack_async,
    output logic o_ack_sync
);

    logic [NUM_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[NUM_STAGES-2:0], i_ack_async};
        end
    end

    assign o_ack_sync = r_sync[NUM_STAGES-1];

endmodule : ack_sync_stage
`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module      : cdc_handshake_tx
// Description : Source side of a 4-phase req/ack CDC handshake with optional
//               ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx
    import cdc_handshake_tx_pkg::*;
#(
    parameter int NUM_STAGES  = c_DEF_NUM_STAGES,
    parameter int BUS_WIDTH   = 8,
    parameter int ACK_TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 ack_async,
    output logic [BUS_WIDTH-1:0] bus_data,
    output logic                 bus_enable,
    output logic                 tx_done,
    output logic                 tx_err
);

    logic [1:0]           r_state;
    logic [BUS_WIDTH-1:0] r_bus_data;
    logic                 r_bus_enable;
    logic                 r_tx_done;
    logic                 r_tx_err;
    logic                 w_ack_sync;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_timeout;

    ack_sync_stage #(
        .NUM_STAGES (NUM_STAGES)
    ) u_ack_sync (
        .clk         (clk),
        .reset       (reset),
        .i_ack_async (ack_async),
        .o_ack_sync  (w_ack_sync)
    );

    // A lingering ack from the previous transfer blocks a new launch.
    assign w_in_ready = (r_state == c_ST_IDLE) && !w_ack_sync;
    assign w_accept   = w_in_ready && in_valid;

    generate
        if (ACK_TIMEOUT > 0) begin : g_timeout
            localparam int                 c_CNT_W    = $clog2(ACK_TIMEOUT + 1);
            localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACK_TIMEOUT - 1);
            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cnt <= '0;
                end else if (w_accept || (r_state != c_ST_REQ)) begin
                    r_cnt <= '0;
                end else if (r_cnt != c_CNT_LAST) begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end

            assign w_timeout = (r_state == c_ST_REQ) && (r_cnt == c_CNT_LAST);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_bus_data   <= '0;
            r_bus_enable <= 1'b0;
            r_tx_done    <= 1'b0;
            r_tx_err     <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            r_tx_err  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_bus_data   <= in_data;
                        r_bus_enable <= 1'b1;
                        r_state      <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    // Ack takes priority over a timeout on the same edge.
                    if (w_ack_sync) begin
                        r_bus_enable <= 1'b0;
                        r_tx_done    <= 1'b1;
                        r_state      <= c_ST_WAIT_LOW;
                    end else if (w_timeout) begin
                        r_bus_enable <= 1'b0;
                        r_tx_err     <= 1'b1;
                        r_state      <= c_ST_WAIT_LOW;
                    end
                end
                c_ST_WAIT_LOW: begin
                    if (!w_ack_sync) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_bus_enable <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign bus_data   = r_bus_data;
    assign bus_enable = r_bus_enable;
    assign tx_done    = r_tx_done;
    assign tx_err     = r_tx_err;

endmodule : cdc_handshake_tx
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_handshake_tx
// Description : Directed self-checking bench for cdc_handshake_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_tx;

    logic       clk   = 1'b0;
    logic       clk_d = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       ack_man  = 1'b0;
    logic       ack_loop;
    logic       loop_en  = 1'b0;
    logic       ack_async;
    logic [7:0] bus_data;
    logic       bus_enable;
    logic       tx_done;
    logic       tx_err;

    int n_cmp = 0;
    int n_err = 0;
    int done_total = 0;

    logic       d_s1, d_s2;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;
    always #7 clk_d = ~clk_d;

    assign ack_async = loop_en ? ack_loop : ack_man;

    cdc_handshake_tx #(
        .NUM_STAGES  (2),
        .BUS_WIDTH   (8),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ack_async  (ack_async),
        .bus_data   (bus_data),
        .bus_enable (bus_enable),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    // Destination-domain model: sync the request, capture on its rise, ack back.
    always @(posedge clk_d or negedge reset) begin
        if (!reset) begin
            d_s1     <= 1'b0;
            d_s2     <= 1'b0;
            ack_loop <= 1'b0;
        end else begin
            d_s1 <= bus_enable;
            d_s2 <= d_s1;
            if (loop_en && d_s2 && !ack_loop) begin
                rx_q.push_back(bus_data);
                ack_loop <= 1'b1;
            end else if (!d_s2) begin
                ack_loop <= 1'b0;
            end
        end
    end

    always @(negedge clk) if (tx_done === 1'b1) done_total++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++; if (bus_enable !== 1'b0) begin n_err++; $display("FAIL rst_enable: got %b want 0", bus_enable); end
        n_cmp++; if (bus_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", bus_data); end
        n_cmp++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", tx_done); end
        n_cmp++; if (tx_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", tx_err); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        launch(8'hA5);
        n_cmp++; if (bus_data !== 8'hA5) begin n_err++; $display("FAIL basic_data: got %h want a5", bus_data); end
        n_cmp++; if (bus_enable !== 1'b1) begin n_err++; $display("FAIL basic_enable: got %b want 1", bus_enable); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %b want 0", in_ready); end
        tick(); tick(); tick();
        ack_man = 1'b1;
        tick(); tick();
        n_cmp++; if (tx_done !== 1'b0 || bus_enable !== 1'b1) begin n_err++; $display("FAIL basic_early: got done=%b en=%b want done=0 en=1", tx_done, bus_enable); end
        tick();
        n_cmp++; if (tx_done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", tx_done); end
        n_cmp++; if (bus_enable !== 1'b0) begin n_err++; $display("FAIL basic_enable_fall: got %b want 0", bus_enable); end
        ack_man = 1'b0;
        tick();
        n_cmp++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL basic_pulse: got %b want 0", tx_done); end
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_early: got %b want 0", in_ready); end
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_busy_reject();
        launch(8'hA5);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick(); tick(); tick();
        n_cmp++; if (bus_data !== 8'hA5) begin n_err++; $display("FAIL busy_req_data: got %h want a5", bus_data); end
        ack_man = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (tx_done !== 1'b1) begin n_err++; $display("FAIL busy_done: got %b want 1", tx_done); end
        tick(); tick();
        n_cmp++; if (bus_data !== 8'hA5 || bus_enable !== 1'b0) begin n_err++; $display("FAIL busy_wait_low: got data=%h en=%b want a5/0", bus_data, bus_enable); end
        in_valid = 1'b0;
        ack_man  = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (in_ready !== 1'b1 || bus_data !== 8'hA5) begin n_err++; $display("FAIL busy_idle: got rdy=%b data=%h want 1/a5", in_ready, bus_data); end
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        launch(8'h77);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (bus_enable !== 1'b1 || tx_err !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL to_hold: got %0d bad cycles want 0", bad); end
        tick();
        n_cmp++; if (bus_enable !== 1'b0) begin n_err++; $display("FAIL to_enable: got %b want 0", bus_enable); end
        n_cmp++; if (tx_err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", tx_err); end
        n_cmp++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL to_done: got %b want 0", tx_done); end
        tick();
        n_cmp++; if (tx_err !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL to_after: got err=%b rdy=%b want 0/1", tx_err, in_ready); end
    endtask

    task automatic test_collision();
        launch(8'h99);
        tick(); tick(); tick(); tick(); tick();
        ack_man = 1'b1;
        tick(); tick();
        n_cmp++; if (bus_enable !== 1'b1 || tx_done !== 1'b0) begin n_err++; $display("FAIL col_before: got en=%b done=%b want 1/0", bus_enable, tx_done); end
        tick();
        n_cmp++; if (tx_done !== 1'b1 || tx_err !== 1'b0) begin n_err++; $display("FAIL col_win: got done=%b err=%b want 1/0", tx_done, tx_err); end
        ack_man = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL col_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_total;
        launch(8'h5A);
        tick(); tick();
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (bus_enable !== 1'b0 || bus_data !== 8'h00) begin n_err++; $display("FAIL rm_immediate: got en=%b data=%h want 0/00", bus_enable, bus_data); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1 || bus_enable !== 1'b0) begin n_err++; $display("FAIL rm_release: got rdy=%b en=%b want 1/0", in_ready, bus_enable); end
        n_cmp++; if (tx_err !== 1'b0 || done_total !== d0) begin n_err++; $display("FAIL rm_no_pulse: got err=%b dones=%0d want 0/%0d", tx_err, done_total, d0); end
    endtask

    task automatic test_back_to_back();
        int d0, t;
        logic [7:0] exp_w, got_w;
        d0 = done_total;
        rx_q.delete();
        loop_en = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            t = 0;
            while (in_ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
            n_cmp++; if (t >= 300) begin n_err++; $display("FAIL b2b_ready_timeout: got in_ready=%b want 1", in_ready); end
            in_valid = 1'b1;
            in_data  = 8'(w);
            tick();
            in_valid = 1'b0;
        end
        t = 0;
        while ((rx_q.size() < 4 || in_ready !== 1'b1) && t < 400) begin @(negedge clk); t++; end
        n_cmp++; if (rx_q.size() != 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", rx_q.size()); end
        for (int i = 0; i < 4; i++) begin
            exp_w = 8'(i + 1);
            got_w = (rx_q.size() > i) ? rx_q[i] : 8'hxx;
            n_cmp++; if (got_w !== exp_w) begin n_err++; $display("FAIL b2b_word%0d: got %h want %h", i, got_w, exp_w); end
        end
        n_cmp++; if (done_total - d0 != 4) begin n_err++; $display("FAIL b2b_done: got %0d want 4", done_total - d0); end
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_reject();
        test_timeout();
        test_collision();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_cdc_handshake_tx
`default_nettype wire
